// File: rtl/cpu_pkg.sv
// Shared definitions for the SCI host bridge: master FSM states, SCI register
// map and SSR flag positions.
package cpu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SSR_RD,
        SSR_WAIT,
        RDR_RD,
        RDR_WAIT,
        RX_CLR,
        TDR_WR,
        TX_CLR
    } bridge_state_t;

    localparam logic [31:0] SCI_TDR_ADDR = 32'hFFFF_FE03;
    localparam logic [31:0] SCI_SSR_ADDR = 32'hFFFF_FE04;
    localparam logic [31:0] SCI_RDR_ADDR = 32'hFFFF_FE05;

    localparam logic [3:0] LANE_TDR = 4'b0001;
    localparam logic [3:0] LANE_SSR = 4'b1000;
    localparam logic [3:0] LANE_RDR = 4'b0100;

    localparam int SSR_TDRE_BIT = 7;
    localparam int SSR_RDRF_BIT = 6;

    // SSR flags clear on a written 0; the other flag is written 1 to leave it alone.
    localparam logic [7:0] SSR_ACK_RDRF = 8'hBE;
    localparam logic [7:0] SSR_START_TX = 8'h7E;

endpackage

// File: rtl/sci_byte_fifo.sv
// Byte FIFO with wrap-bit pointers; head is read combinationally from storage,
// which is deliberately left without reset.
module sci_byte_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] head,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;

    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge CLK) begin
        if (do_push && !RST) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/sci_host_bridge.sv
// Bridges host byte streams to an SCI peripheral by polling SSR over the
// internal bus; received bytes take priority over transmit.
//
//  state    | meaning
//  IDLE     | wait for RDRF interrupt or pending TX byte
//  SSR_RD   | issue SSR read
//  SSR_WAIT | sample SSR, pick RX, TX or back to IDLE
//  RDR_RD   | issue RDR read
//  RDR_WAIT | sample RDR, push to RX FIFO or flag overflow
//  RX_CLR   | write SSR to clear RDRF
//  TDR_WR   | write TX FIFO head to TDR
//  TX_CLR   | write SSR to clear TDRE (starts TX), pop TX head
module sci_host_bridge
    import cpu_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CE,
    input  logic [7:0]  TX_DATA,
    input  logic        TX_VALID,
    output logic        TX_READY,
    output logic [7:0]  RX_DATA,
    output logic        RX_VALID,
    input  logic        RX_READY,
    output logic        RX_OVF,
    input  logic        SCI_RXI,
    output logic [31:0] IBUS_A,
    output logic [31:0] IBUS_DO,
    input  logic [31:0] IBUS_DI,
    output logic [3:0]  IBUS_BA,
    output logic        IBUS_WE,
    output logic        IBUS_REQ,
    input  logic        IBUS_BUSY
);

    bridge_state_t state;
    bridge_state_t state_nxt;

    logic       tx_full;
    logic       tx_empty;
    logic       rx_full;
    logic       rx_empty;
    logic [7:0] tx_head;
    logic [7:0] ssr;
    logic       rx_push_req;
    logic       tx_pop_req;
    logic       ovf_set;
    logic       unused_bits;

    assign ssr         = IBUS_DI[31:24];
    assign unused_bits = ^{ssr[5:0], IBUS_DI[15:0]};
    assign TX_READY    = !tx_full;
    assign RX_VALID    = !rx_empty;

    sci_byte_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
        .CLK       (CLK),
        .RST       (RST),
        .push      (CE && TX_VALID && !tx_full),
        .push_data (TX_DATA),
        .pop       (CE && tx_pop_req),
        .head      (tx_head),
        .full      (tx_full),
        .empty     (tx_empty)
    );

    sci_byte_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
        .CLK       (CLK),
        .RST       (RST),
        .push      (CE && rx_push_req),
        .push_data (IBUS_DI[23:16]),
        .pop       (CE && RX_READY && !rx_empty),
        .head      (RX_DATA),
        .full      (rx_full),
        .empty     (rx_empty)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else if (CE) begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            RX_OVF <= 1'b0;
        end else if (CE && ovf_set) begin
            RX_OVF <= 1'b1;
        end
    end

    // Bus outputs depend only on state and TX head, so a stall holds them unchanged.
    always_comb begin
        state_nxt   = state;
        IBUS_A      = '0;
        IBUS_DO     = '0;
        IBUS_BA     = '0;
        IBUS_WE     = 1'b0;
        IBUS_REQ    = 1'b0;
        rx_push_req = 1'b0;
        tx_pop_req  = 1'b0;
        ovf_set     = 1'b0;
        case (state)
            IDLE: begin
                if (SCI_RXI || !tx_empty) state_nxt = SSR_RD;
            end
            SSR_RD: begin
                IBUS_A   = SCI_SSR_ADDR;
                IBUS_BA  = LANE_SSR;
                IBUS_REQ = 1'b1;
                if (!IBUS_BUSY) state_nxt = SSR_WAIT;
            end
            SSR_WAIT: begin
                if (ssr[SSR_RDRF_BIT]) begin
                    state_nxt = RDR_RD;
                end else if (ssr[SSR_TDRE_BIT] && !tx_empty) begin
                    state_nxt = TDR_WR;
                end else begin
                    state_nxt = IDLE;
                end
            end
            RDR_RD: begin
                IBUS_A   = SCI_RDR_ADDR;
                IBUS_BA  = LANE_RDR;
                IBUS_REQ = 1'b1;
                if (!IBUS_BUSY) state_nxt = RDR_WAIT;
            end
            RDR_WAIT: begin
                if (rx_full) begin
                    ovf_set = 1'b1;
                end else begin
                    rx_push_req = 1'b1;
                end
                state_nxt = RX_CLR;
            end
            RX_CLR: begin
                IBUS_A   = SCI_SSR_ADDR;
                IBUS_BA  = LANE_SSR;
                IBUS_DO  = {SSR_ACK_RDRF, 24'h0};
                IBUS_WE  = 1'b1;
                IBUS_REQ = 1'b1;
                if (!IBUS_BUSY) state_nxt = IDLE;
            end
            TDR_WR: begin
                IBUS_A   = SCI_TDR_ADDR;
                IBUS_BA  = LANE_TDR;
                IBUS_DO  = {24'h0, tx_head};
                IBUS_WE  = 1'b1;
                IBUS_REQ = 1'b1;
                if (!IBUS_BUSY) state_nxt = TX_CLR;
            end
            TX_CLR: begin
                IBUS_A   = SCI_SSR_ADDR;
                IBUS_BA  = LANE_SSR;
                IBUS_DO  = {SSR_START_TX, 24'h0};
                IBUS_WE  = 1'b1;
                IBUS_REQ = 1'b1;
                if (!IBUS_BUSY) begin
                    tx_pop_req = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_sci_host_bridge.sv
// Self-checking bench for sci_host_bridge: directed vector table, hand-written
// corner sequences and a randomized run against a queue-based SCI/host model.
module tb_sci_host_bridge;

    localparam int DEPTH = 8;

    logic        CLK = 1'b0;
    logic        RST;
    logic        CE;
    logic [7:0]  TX_DATA;
    logic        TX_VALID;
    logic        TX_READY;
    logic [7:0]  RX_DATA;
    logic        RX_VALID;
    logic        RX_READY;
    logic        RX_OVF;
    logic        SCI_RXI;
    logic [31:0] IBUS_A;
    logic [31:0] IBUS_DO;
    logic [31:0] IBUS_DI;
    logic [3:0]  IBUS_BA;
    logic        IBUS_WE;
    logic        IBUS_REQ;
    logic        IBUS_BUSY;

    logic [7:0]  sci_ssr;
    logic [7:0]  sci_rdr;
    logic [7:0]  sci_tdr;

    assign SCI_RXI = sci_ssr[6];
    assign IBUS_DI = {sci_ssr, sci_rdr, 16'h0};

    always #5 CLK = ~CLK;

    sci_host_bridge #(.DEPTH(DEPTH)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .CE        (CE),
        .TX_DATA   (TX_DATA),
        .TX_VALID  (TX_VALID),
        .TX_READY  (TX_READY),
        .RX_DATA   (RX_DATA),
        .RX_VALID  (RX_VALID),
        .RX_READY  (RX_READY),
        .RX_OVF    (RX_OVF),
        .SCI_RXI   (SCI_RXI),
        .IBUS_A    (IBUS_A),
        .IBUS_DO   (IBUS_DO),
        .IBUS_DI   (IBUS_DI),
        .IBUS_BA   (IBUS_BA),
        .IBUS_WE   (IBUS_WE),
        .IBUS_REQ  (IBUS_REQ),
        .IBUS_BUSY (IBUS_BUSY)
    );

    typedef struct packed {
        logic [31:0] a;
        logic [3:0]  ba;
        logic        we;
        logic [31:0] dout;
    } acc_t;

    typedef struct {
        string       name;
        logic        do_tx;
        logic [7:0]  tx_b;
        logic [7:0]  ssr0;
        logic [7:0]  rdr;
        int          n_acc;
        acc_t [5:0]  exp;
        logic        exp_rxv;
        logic [7:0]  exp_rxd;
    } vec_t;

    localparam acc_t R_SSR    = '{32'hFFFF_FE04, 4'b1000, 1'b0, 32'h0};
    localparam acc_t R_RDR    = '{32'hFFFF_FE05, 4'b0100, 1'b0, 32'h0};
    localparam acc_t W_ACK_RX = '{32'hFFFF_FE04, 4'b1000, 1'b1, 32'hBE00_0000};
    localparam acc_t W_GO_TX  = '{32'hFFFF_FE04, 4'b1000, 1'b1, 32'h7E00_0000};

    function automatic acc_t w_tdr(input logic [7:0] b);
        acc_t r;
        r.a    = 32'hFFFF_FE03;
        r.ba   = 4'b0001;
        r.we   = 1'b1;
        r.dout = {24'h0, b};
        return r;
    endfunction

    acc_t       acc_q[$];
    logic [7:0] tx_pushed[$];
    logic [7:0] tx_line[$];
    logic [7:0] rx_model[$];
    int         n_chk  = 0;
    int         n_pass = 0;
    bit         rnd_on = 1'b0;
    vec_t       vecs[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Runs at the falling edge: records the access the next rising edge accepts,
    // updates the SCI register model and, in the random run, the host scoreboard.
    task automatic sample();
        acc_t acc;
        logic exp_rdy;
        if (RST || !CE) return;
        if (rnd_on) begin
            exp_rdy = (tx_pushed.size() - tx_line.size()) < DEPTH;
            chk("rnd_tx_ready", 32'(TX_READY), 32'(exp_rdy));
        end
        if (IBUS_REQ && !IBUS_BUSY) begin
            acc = '{IBUS_A, IBUS_BA, IBUS_WE, IBUS_DO};
            acc_q.push_back(acc);
            if (IBUS_WE && IBUS_A == 32'hFFFF_FE03) sci_tdr = IBUS_DO[7:0];
            if (IBUS_WE && IBUS_A == 32'hFFFF_FE04) begin
                if (!IBUS_DO[30]) sci_ssr[6] = 1'b0;
                if (!IBUS_DO[31] && sci_ssr[7]) tx_line.push_back(sci_tdr);
            end
        end
        if (rnd_on) begin
            if (TX_VALID && TX_READY) tx_pushed.push_back(TX_DATA);
            if (RX_READY && RX_VALID) begin
                if (rx_model.size() == 0) begin
                    chk("rnd_rx_spurious_valid", 32'(RX_VALID), 32'h0);
                end else begin
                    chk("rnd_rx_data", 32'(RX_DATA), 32'(rx_model[0]));
                    void'(rx_model.pop_front());
                end
            end
        end
    endtask

    task automatic cycle();
        @(negedge CLK);
        sample();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST       = 1'b1;
        CE        = 1'b1;
        TX_VALID  = 1'b0;
        RX_READY  = 1'b0;
        IBUS_BUSY = 1'b0;
        sci_ssr   = 8'h00;
        cycle();
        cycle();
        RST = 1'b0;
        acc_q.delete();
        tx_line.delete();
        tx_pushed.delete();
        rx_model.delete();
    endtask

    task automatic sci_receive(input logic [7:0] b);
        sci_rdr    = b;
        sci_ssr[6] = 1'b1;
        for (int k = 0; k < 100 && sci_ssr[6]; k++) cycle();
        chk("rx_byte_taken", 32'(sci_ssr[6]), 32'h0);
    endtask

    initial begin
        logic [7:0] b;
        bit         found;
        int         n_tdr;
        int         n_go;

        sci_ssr = 8'h00;
        sci_rdr = 8'h00;
        sci_tdr = 8'h00;
        TX_DATA = 8'h00;

        vecs[0].name = "tx_byte";  vecs[0].do_tx = 1'b1; vecs[0].tx_b = 8'h5A;
        vecs[0].ssr0 = 8'h84;      vecs[0].rdr = 8'h00;  vecs[0].n_acc = 3;
        vecs[0].exp[0] = R_SSR;    vecs[0].exp[1] = w_tdr(8'h5A); vecs[0].exp[2] = W_GO_TX;
        vecs[0].exp_rxv = 1'b0;    vecs[0].exp_rxd = 8'h00;

        vecs[1].name = "rx_byte";  vecs[1].do_tx = 1'b0; vecs[1].tx_b = 8'h00;
        vecs[1].ssr0 = 8'h40;      vecs[1].rdr = 8'hC3;  vecs[1].n_acc = 3;
        vecs[1].exp[0] = R_SSR;    vecs[1].exp[1] = R_RDR; vecs[1].exp[2] = W_ACK_RX;
        vecs[1].exp_rxv = 1'b1;    vecs[1].exp_rxd = 8'hC3;

        vecs[2].name = "rx_prio";  vecs[2].do_tx = 1'b1; vecs[2].tx_b = 8'h11;
        vecs[2].ssr0 = 8'hC0;      vecs[2].rdr = 8'h6E;  vecs[2].n_acc = 6;
        vecs[2].exp[0] = R_SSR;    vecs[2].exp[1] = R_RDR; vecs[2].exp[2] = W_ACK_RX;
        vecs[2].exp[3] = R_SSR;    vecs[2].exp[4] = w_tdr(8'h11); vecs[2].exp[5] = W_GO_TX;
        vecs[2].exp_rxv = 1'b1;    vecs[2].exp_rxd = 8'h6E;

        vecs[3].name = "idle_quiet"; vecs[3].do_tx = 1'b0; vecs[3].tx_b = 8'h00;
        vecs[3].ssr0 = 8'h80;        vecs[3].rdr = 8'h00;  vecs[3].n_acc = 0;
        vecs[3].exp_rxv = 1'b0;      vecs[3].exp_rxd = 8'h00;

        // reset state
        do_reset();
        chk("rst_tx_ready", 32'(TX_READY), 32'h1);
        chk("rst_rx_valid", 32'(RX_VALID), 32'h0);
        chk("rst_rx_ovf",   32'(RX_OVF),   32'h0);
        chk("rst_req",      32'(IBUS_REQ), 32'h0);
        chk("rst_we",       32'(IBUS_WE),  32'h0);
        chk("rst_a",        IBUS_A,        32'h0);
        chk("rst_do",       IBUS_DO,       32'h0);
        chk("rst_ba",       32'(IBUS_BA),  32'h0);

        // directed vector table
        for (int v = 0; v < 4; v++) begin
            do_reset();
            sci_ssr  = vecs[v].ssr0;
            sci_rdr  = vecs[v].rdr;
            TX_DATA  = vecs[v].tx_b;
            TX_VALID = vecs[v].do_tx;
            cycle();
            TX_VALID = 1'b0;
            repeat (40) cycle();
            chk($sformatf("%s_n_acc", vecs[v].name), 32'(acc_q.size()), 32'(vecs[v].n_acc));
            for (int k = 0; k < vecs[v].n_acc && k < acc_q.size(); k++) begin
                chk($sformatf("%s_acc%0d_a", vecs[v].name, k), acc_q[k].a, vecs[v].exp[k].a);
                chk($sformatf("%s_acc%0d_ba", vecs[v].name, k), 32'(acc_q[k].ba), 32'(vecs[v].exp[k].ba));
                chk($sformatf("%s_acc%0d_we", vecs[v].name, k), 32'(acc_q[k].we), 32'(vecs[v].exp[k].we));
                chk($sformatf("%s_acc%0d_do", vecs[v].name, k), acc_q[k].dout, vecs[v].exp[k].dout);
            end
            chk($sformatf("%s_rx_valid", vecs[v].name), 32'(RX_VALID), 32'(vecs[v].exp_rxv));
            if (vecs[v].exp_rxv)
                chk($sformatf("%s_rx_data", vecs[v].name), 32'(RX_DATA), 32'(vecs[v].exp_rxd));
            chk($sformatf("%s_tx_sent", vecs[v].name), 32'(tx_line.size()), 32'(vecs[v].do_tx));
        end

        // TX FIFO fills while TDRE=0, then drains in order once TDRE rises
        do_reset();
        sci_ssr = 8'h00;
        for (int i = 0; i < DEPTH; i++) begin
            chk($sformatf("txfull_ready_%0d", i), 32'(TX_READY), 32'h1);
            TX_DATA  = 8'(8'h10 + i);
            TX_VALID = 1'b1;
            cycle();
        end
        TX_VALID = 1'b0;
        chk("txfull_ready_full", 32'(TX_READY), 32'h0);
        chk("txfull_none_sent", 32'(tx_line.size()), 32'h0);
        sci_ssr = 8'h80;
        for (int k = 0; k < 400 && tx_line.size() < DEPTH; k++) cycle();
        chk("txfull_sent_count", 32'(tx_line.size()), 32'(DEPTH));
        for (int i = 0; i < DEPTH && i < tx_line.size(); i++)
            chk($sformatf("txfull_byte_%0d", i), 32'(tx_line[i]), 32'(8'h10 + i));
        chk("txfull_ready_after", 32'(TX_READY), 32'h1);

        // RX overflow: DEPTH+1 bytes with the host not popping
        do_reset();
        sci_ssr = 8'h80;
        for (int i = 0; i < DEPTH; i++) sci_receive(8'(8'hA0 + i));
        chk("ovf_not_yet", 32'(RX_OVF), 32'h0);
        sci_receive(8'hEE);
        chk("ovf_set", 32'(RX_OVF), 32'h1);
        for (int i = 0; i < DEPTH; i++) begin
            chk($sformatf("ovf_valid_%0d", i), 32'(RX_VALID), 32'h1);
            chk($sformatf("ovf_data_%0d", i), 32'(RX_DATA), 32'(8'hA0 + i));
            RX_READY = 1'b1;
            cycle();
            RX_READY = 1'b0;
        end
        chk("ovf_drained", 32'(RX_VALID), 32'h0);
        chk("ovf_sticky", 32'(RX_OVF), 32'h1);
        RST = 1'b1;
        cycle();
        RST = 1'b0;
        chk("ovf_cleared_by_rst", 32'(RX_OVF), 32'h0);

        // stall during TDR_WR
        do_reset();
        sci_ssr  = 8'h80;
        TX_DATA  = 8'h3C;
        TX_VALID = 1'b1;
        cycle();
        TX_VALID = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 50 && !found; k++) begin
            if (IBUS_REQ && IBUS_WE && IBUS_A == 32'hFFFF_FE03) found = 1'b1;
            else cycle();
        end
        chk("stall_reach_tdr", 32'(found), 32'h1);
        IBUS_BUSY = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk($sformatf("stall_req_%0d", i), 32'(IBUS_REQ), 32'h1);
            chk($sformatf("stall_we_%0d", i),  32'(IBUS_WE),  32'h1);
            chk($sformatf("stall_a_%0d", i),   IBUS_A,        32'hFFFF_FE03);
            chk($sformatf("stall_ba_%0d", i),  32'(IBUS_BA),  32'h1);
            chk($sformatf("stall_do_%0d", i),  IBUS_DO,       32'h0000_003C);
        end
        IBUS_BUSY = 1'b0;
        repeat (20) cycle();
        n_tdr = 0;
        n_go  = 0;
        foreach (acc_q[k]) begin
            if (acc_q[k] == w_tdr(8'h3C)) n_tdr++;
            if (acc_q[k] == W_GO_TX) n_go++;
        end
        chk("stall_tdr_writes", 32'(n_tdr), 32'h1);
        chk("stall_tx_clr_writes", 32'(n_go), 32'h1);
        chk("stall_sent_count", 32'(tx_line.size()), 32'h1);
        if (tx_line.size() > 0) chk("stall_sent_byte", 32'(tx_line[0]), 32'h3C);

        // reset while waiting for RDR data
        do_reset();
        sci_rdr = 8'h99;
        sci_ssr = 8'h40;
        found = 1'b0;
        for (int k = 0; k < 50 && !found; k++) begin
            if (IBUS_REQ && !IBUS_WE && IBUS_A == 32'hFFFF_FE05) found = 1'b1;
            else cycle();
        end
        chk("rstmid_reach_rdr", 32'(found), 32'h1);
        cycle();
        chk("rstmid_in_wait_req", 32'(IBUS_REQ), 32'h0);
        RST     = 1'b1;
        sci_ssr = 8'h00;
        cycle();
        chk("rstmid_req", 32'(IBUS_REQ), 32'h0);
        chk("rstmid_we",  32'(IBUS_WE),  32'h0);
        chk("rstmid_a",   IBUS_A,        32'h0);
        chk("rstmid_rx_valid", 32'(RX_VALID), 32'h0);
        RST = 1'b0;
        repeat (10) cycle();
        chk("rstmid_no_push", 32'(RX_VALID), 32'h0);
        chk("rstmid_idle_req", 32'(IBUS_REQ), 32'h0);

        // randomized traffic against the queue model
        do_reset();
        sci_ssr = 8'h80;
        rnd_on  = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            CE        = ($urandom_range(0, 3) != 0);
            IBUS_BUSY = ($urandom_range(0, 3) == 0);
            TX_VALID  = $urandom_range(0, 1) != 0;
            TX_DATA   = 8'($urandom_range(0, 255));
            RX_READY  = $urandom_range(0, 1) != 0;
            if (!sci_ssr[6] && rx_model.size() < DEPTH && $urandom_range(0, 3) == 0) begin
                b          = 8'($urandom_range(0, 255));
                sci_rdr    = b;
                sci_ssr[6] = 1'b1;
                rx_model.push_back(b);
            end
            cycle();
        end
        CE        = 1'b1;
        IBUS_BUSY = 1'b0;
        TX_VALID  = 1'b0;
        RX_READY  = 1'b1;
        for (int k = 0; k < 600 && !(tx_line.size() == tx_pushed.size() && rx_model.size() == 0 && !sci_ssr[6]); k++)
            cycle();
        rnd_on = 1'b0;
        chk("rnd_tx_count", 32'(tx_line.size()), 32'(tx_pushed.size()));
        for (int i = 0; i < tx_pushed.size() && i < tx_line.size(); i++)
            chk($sformatf("rnd_tx_byte_%0d", i), 32'(tx_line[i]), 32'(tx_pushed[i]));
        chk("rnd_rx_left", 32'(rx_model.size()), 32'h0);
        chk("rnd_rx_valid_end", 32'(RX_VALID), 32'h0);
        chk("rnd_rx_ovf", 32'(RX_OVF), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sci_host_bridge.md
SCI_HOST_BRIDGE -- requirements
Module: sci_host_bridge

Interface
REQ-001 Parameter DEPTH, default 8, SHALL set the entry count of each byte FIFO (power of two, 2..16).
REQ-002 Ports, one per line, name direction width meaning:
  CLK  in  1  system clock; one clock; all state changes on its rising edge.
  RST  in  1  synchronous, active-high reset.
  CE  in  1  clock enable; state advances only in cycles with CE=1.
  TX_DATA  in  8  host byte to transmit.
  TX_VALID  in  1  TX_DATA offered.
  TX_READY  out  1  TX FIFO not full.
  RX_DATA  out  8  head of RX FIFO.
  RX_VALID  out  1  RX FIFO not empty.
  RX_READY  in  1  host pops RX head.
  RX_OVF  out  1  sticky: byte dropped because the RX FIFO was full.
  SCI_RXI  in  1  SCI receive-full interrupt (RDRF).
  IBUS_A  out  32  bus address.
  IBUS_DO  out  32  write data to SCI.
  IBUS_DI  in  32  read data from SCI.
  IBUS_BA  out  4  byte lanes.
  IBUS_WE  out  1  write strobe.
  IBUS_REQ  out  1  access request.
  IBUS_BUSY  in  1  slave stall.

Function
REQ-003 Handshakes SHALL complete on a CE cycle with VALID=1 and READY=1; a TX push and an RX pop in the same cycle SHALL both take effect.
REQ-004 TX_READY=1 SHALL mean the TX FIFO is not full; a push to a full FIFO SHALL be impossible because TX_READY=0.
REQ-005 RX_DATA SHALL be the FIFO head, combinational from storage; RX_VALID=1 SHALL mean the RX FIFO is not empty.
REQ-006 The FIFO pointers SHALL be log2(DEPTH)+1 bits and SHALL wrap. Full SHALL be MSBs differ with the LSBs equal. Empty SHALL be equal pointers.
REQ-007 The master FSM states SHALL be IDLE, SSR_RD, SSR_WAIT, RDR_RD, RDR_WAIT, RX_CLR, TDR_WR and TX_CLR.
REQ-008 IDLE->SSR_RD SHALL occur when SCI_RXI=1 or the TX FIFO is non-empty.
REQ-009 SSR_RD SHALL drive a read with A=FFFFFE04, BA=1000, REQ=1 and WE=0.
REQ-010 SSR_WAIT SHALL sample IBUS_DI[31:24] as SSR.
REQ-011 After SSR_WAIT, if SSR[6] (RDRF)=1, next state SHALL be RDR_RD; RX has priority over TX.
REQ-012 Otherwise, if SSR[7] (TDRE)=1 and the TX FIFO is non-empty, next state SHALL be TDR_WR.
REQ-013 Otherwise, next state SHALL be IDLE.
REQ-014 RDR_RD SHALL read A=FFFFFE05, BA=0100. RDR_WAIT SHALL sample IBUS_DI[23:16].
REQ-015 On that RDR_WAIT sample, the byte SHALL be pushed if the RX FIFO is not full; if full, the byte SHALL be dropped and RX_OVF set. Then RX_CLR.
REQ-016 RX_CLR SHALL write A=FFFFFE04, BA=1000, DO[31:24]=8'hBE (bit6=0 clears RDRF; bit7=1 leaves TDRE; MPBT=0), then go to IDLE.
REQ-017 TDR_WR SHALL write the TX FIFO head, A=FFFFFE03, BA=0001, DO[7:0]=head.
REQ-018 TX_CLR SHALL write A=FFFFFE04, DO[31:24]=8'h7E (bit7=0 starts transmission), pop the TX head, then go to IDLE.
REQ-019 Each access state SHALL hold REQ=1 for exactly one accepted CE cycle. With IBUS_BUSY=1 the FSM SHALL hold state and all bus outputs.
REQ-020 Read data SHALL be sampled on the CE cycle after REQ (one-cycle read latency).
REQ-021 Outside access states, REQ=0, WE=0, A=0, DO=0 and BA=0.
REQ-022 Write data SHALL be replicated on unused lanes as don't-care zeros.
REQ-023 RX_OVF SHALL stay at 1 until RST.
REQ-024 With CE=0, no state, pointer or output SHALL change.

Reset
REQ-025 RST=1 on a rising CLK edge SHALL, regardless of CE and mid-access:
  - set state IDLE and all pointers 0;
  - set RX_OVF=0, REQ=0, WE=0;
  - leave FIFO data storage uninitialised.
REQ-026 After reset, TX_READY=1 and RX_VALID=0.

Structure
REQ-027 The FSM state enum and the SCI register addresses and SSR bit positions SHALL live in CPU_PKG.
REQ-028 One sub-module, sci_byte_fifo (parameter DEPTH), SHALL be instantiated twice, for TX and RX.

Verification
REQ-029 The bench SHALL cover these scenarios:
  - TX byte: push 8'h5A, SSR model returns 8'h84 -> write FFFFFE03 data 5A, then write FFFFFE04 DO[31:24]=7E; FIFO empty.
  - RX byte: SCI_RXI=1, SSR 8'h40, RDR 8'hC3 -> RX_VALID=1, RX_DATA=C3, SSR write DO[31:24]=BE.
  - RX priority: SSR 8'hC0 with TX pending -> RDR read precedes TDR write.
  - Overflow: DEPTH+1 received bytes, RX_READY=0 -> RX_OVF=1, first DEPTH bytes intact in order.
  - Stall: IBUS_BUSY=1 for 3 cycles during TDR_WR -> bus outputs stable, a single TX_CLR follows.
  - Reset mid-RDR_WAIT -> next cycle IDLE, REQ=0, no push.
